// File: rtl/regfile_2r1w_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w_param
//  Purpose  : DEPTH x DATA_W register file, 2 registered read ports, 1 write
//             port, optional write bypass / hardwired zero entry, and a
//             one-entry-per-cycle clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_2r1w_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_clr,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_data_out1,
    output logic [DATA_W-1:0] o_data_out2
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout1;
    logic [DATA_W-1:0] r_dout2;

    logic              w_idle;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];

    assign w_idle     = (r_state == S_IDLE);
    // A write to entry 0 is discarded when it is hardwired to zero, so it
    // must not be forwarded either.
    assign w_wr_en    = i_wr && w_idle && !((ZERO_REG != 0) && (i_wr_addr == '0));
    assign w_rd_en    = i_rd && w_idle;
    assign w_raddr[0] = i_addr1;
    assign w_raddr[1] = i_addr2;

    genvar gp;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_rd_port
            assign w_rdata[gp] =
                ((ZERO_REG != 0) && (w_raddr[gp] == '0))                    ? '0 :
                ((BYPASS != 0) && w_wr_en && (w_raddr[gp] == i_wr_addr))    ? i_data_in :
                                                                              r_mem[w_raddr[gp]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dout1 <= '0;
            r_dout2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_en) begin
                        r_mem[i_wr_addr] <= i_data_in;
                    end
                    if (w_rd_en) begin
                        r_dout1 <= w_rdata[0];
                        r_dout2 <= w_rdata[1];
                    end
                    if (i_clr) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_mem[r_cnt] <= '0;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state == S_CLEAR);
    assign o_data_out1 = r_dout1;
    assign o_data_out2 = r_dout2;

endmodule
`default_nettype wire
